poly_buf_reader: RTL and testbench

Streaming read-side controller for the 96x32 polynomial buffer: drains one Kyber polynomial (256 × 12-bit coefficients, 8 per 96-bit word) as a valid/ready coefficient stream. It drives the buffer's read address, selects the 12-bit lane, and supports natural or bit-reversed output order, so NTT-stage results can be handed to downstream units in either order. It is the consumer counterpart to whatever writes the buffer.

---
 rtl/kyber_pkg.sv | 26 ++
 rtl/buf_96x32.sv | 29 ++
 rtl/poly_buf_reader.sv | 125 ++++++++++++
 tb/tb_poly_buf_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and helpers.
//   POLY_N  : coefficients per polynomial
//   COEF_W  : coefficient width
//   LANES   : coefficients per buffer word
//   WORD_W  : buffer word width
//   BUF_AW  : buffer address width
//   rev8()  : 8-bit bit reversal used for NTT bit-reversed ordering
package kyber_pkg;

    localparam int unsigned POLY_N = 256;
    localparam int unsigned COEF_W = 12;
    localparam int unsigned LANES  = 8;
    localparam int unsigned WORD_W = 96;
    localparam int unsigned BUF_AW = 5;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned CNT_W  = 9;

    function automatic logic [IDX_W-1:0] rev8(input logic [IDX_W-1:0] x);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < int'(IDX_W); i++) begin
            r[i] = x[IDX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/buf_96x32.sv
// 32-entry x 96-bit polynomial buffer: synchronous write, combinational read.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data (8 x 12-bit coefficients)
//   raddr_i  : read address
//   rdata_o  : read data, combinational in raddr_i
module buf_96x32
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [BUF_AW-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BUF_AW-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/poly_buf_reader.sv
// Streaming read controller for the 96x32 polynomial buffer. Drains one
// 256-coefficient polynomial as a valid/ready stream in natural or
// bit-reversed order.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a stream (sampled only when idle)
//   bitrev      : order select, latched on accepted start
//   buf_raddr   : buffer read address (combinational)
//   buf_dout    : buffer read data (combinational in buf_raddr)
//   coef_out    : coefficient data
//   coef_idx    : natural index of coef_out
//   coef_valid  : output register holds a coefficient
//   coef_ready  : downstream accepts
//   coef_last   : marks the 256th beat
//   busy        : controller not idle
//   done        : one-cycle pulse after the last handshake
module poly_buf_reader
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bitrev,
    output logic [BUF_AW-1:0] buf_raddr,
    input  logic [WORD_W-1:0] buf_dout,
    output logic [COEF_W-1:0] coef_out,
    output logic [IDX_W-1:0]  coef_idx,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              coef_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    localparam logic [CNT_W-1:0] LastPos = CNT_W'(POLY_N - 1);
    localparam logic [CNT_W-1:0] EndPos  = CNT_W'(POLY_N);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mode_q;
    logic [COEF_W-1:0]  coef_out_q;
    logic [IDX_W-1:0]   coef_idx_q;
    logic               valid_q;
    logic               last_q;
    logic               done_q;

    logic [IDX_W-1:0]   idx;
    logic [COEF_W-1:0]  lane_data;

    // cnt is 0 whenever idle, so a stale mode_q still maps to index 0 there.
    always_comb begin
        idx = mode_q ? rev8(cnt_q[IDX_W-1:0]) : cnt_q[IDX_W-1:0];
    end

    assign buf_raddr = idx[IDX_W-1:3];

    always_comb begin
        lane_data = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (idx[2:0] == 3'(k)) begin
                lane_data = buf_dout[k*COEF_W +: COEF_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            coef_out_q <= '0;
            coef_idx_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q     <= bitrev;
                        coef_out_q <= lane_data;
                        coef_idx_q <= idx;
                        valid_q    <= 1'b1;
                        last_q     <= 1'b0;
                        cnt_q      <= CNT_W'(1);
                        state_q    <= StStream;
                    end
                end
                StStream: begin
                    // Refill the output register whenever it is empty or being consumed.
                    if ((!valid_q || coef_ready) && (cnt_q < EndPos)) begin
                        coef_out_q <= lane_data;
                        coef_idx_q <= idx;
                        valid_q    <= 1'b1;
                        last_q     <= (cnt_q == LastPos);
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (cnt_q == LastPos) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (valid_q && coef_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign coef_out   = coef_out_q;
    assign coef_idx   = coef_idx_q;
    assign coef_valid = valid_q;
    assign coef_last  = last_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_poly_buf_reader.sv
module tb_poly_buf_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bitrev = 1'b0;
    logic        coef_ready = 1'b0;
    logic [4:0]  buf_raddr;
    logic [95:0] buf_dout;
    logic [11:0] coef_out;
    logic [7:0]  coef_idx;
    logic        coef_valid;
    logic        coef_last;
    logic        busy;
    logic        done;

    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [95:0] wdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buf_96x32 u_buf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_dout)
    );

    poly_buf_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bitrev     (bitrev),
        .buf_raddr  (buf_raddr),
        .buf_dout   (buf_dout),
        .coef_out   (coef_out),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_last  (coef_last),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [7:0] rev(input logic [7:0] x);
        return {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7]};
    endfunction

    function automatic logic [7:0] exp_idx(input bit m, input int b);
        logic [7:0] v;
        v = b[7:0];
        return m ? rev(v) : v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload;
        for (int w = 0; w < 32; w++) begin
            for (int k = 0; k < 8; k++) begin
                wdata[k*12 +: 12] = 12'(8 * w + k);
            end
            waddr = 5'(w);
            we = 1'b1;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({coef_valid, coef_last, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got v/l/b/d=%b required 0000",
                     {coef_valid, coef_last, busy, done});
        end
        checks++;
        if (coef_out !== 12'd0 || coef_idx !== 8'd0 || buf_raddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: got out=%0d idx=%0d raddr=%0d required 0/0/0",
                     coef_out, coef_idx, buf_raddr);
        end
    endtask

    task automatic start_stream(input bit m);
        bitrev = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle T+1; returns in the cycle after done (or T'+1 if chained).
    task automatic check_stream(input bit m, input bit rnd, input int stall_beat,
                                input int pulse_beat, input bit chain, input bit chain_mode,
                                output int cycles);
        int b;
        int stalls;
        int guard;
        logic [7:0] nxt;
        logic [4:0] exp_ra;
        b = 0;
        stalls = 0;
        guard = 0;
        cycles = 0;
        while (b < 256 && guard < 3000) begin
            guard++;
            start = 1'b0;
            checks++;
            if (coef_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL stream_ctrl beat %0d: got v/b/d=%b%b%b required 110",
                         b, coef_valid, busy, done);
            end
            checks++;
            if (coef_out !== {4'b0, exp_idx(m, b)}) begin
                errors++;
                $display("FAIL coef_out beat %0d mode %0d: got %0d required %0d",
                         b, m, coef_out, exp_idx(m, b));
            end
            checks++;
            if (coef_idx !== exp_idx(m, b)) begin
                errors++;
                $display("FAIL coef_idx beat %0d mode %0d: got %0d required %0d",
                         b, m, coef_idx, exp_idx(m, b));
            end
            checks++;
            if (coef_last !== (b == 255)) begin
                errors++;
                $display("FAIL coef_last beat %0d: got %b required %b", b, coef_last, b == 255);
            end
            nxt = exp_idx(m, b + 1);
            exp_ra = (b == 255) ? 5'd0 : nxt[7:3];
            checks++;
            if (buf_raddr !== exp_ra) begin
                errors++;
                $display("FAIL buf_raddr beat %0d: got %0d required %0d", b, buf_raddr, exp_ra);
            end
            if (b == stall_beat && stalls < 3) begin
                coef_ready = 1'b0;
                stalls++;
            end else if (rnd) begin
                coef_ready = 1'($urandom_range(0, 1));
            end else begin
                coef_ready = 1'b1;
            end
            if (b == pulse_beat) begin
                start = 1'b1;
                bitrev = 1'b1;
            end
            if (coef_ready) b++;
            tick();
            cycles++;
        end
        start = 1'b0;
        coef_ready = 1'b1;
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d beats required 256", b);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || coef_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: got d/b/v=%b%b%b required 100", done, busy, coef_valid);
        end
        if (chain) start_stream(chain_mode);
    endtask

    task automatic test_natural;
        int c;
        coef_ready = 1'b1;
        start_stream(1'b0);
        check_stream(1'b0, 1'b0, -1, -1, 1'b0, 1'b0, c);
        checks++;
        if (c !== 256) begin
            errors++;
            $display("FAIL natural_latency: got %0d cycles required 256", c);
        end
    endtask

    task automatic test_bitrev;
        int c;
        coef_ready = 1'b1;
        start_stream(1'b1);
        checks++;
        if (buf_raddr !== 5'd16) begin
            errors++;
            $display("FAIL bitrev_first_raddr: got %0d required 16", buf_raddr);
        end
        check_stream(1'b1, 1'b0, -1, -1, 1'b0, 1'b0, c);
        checks++;
        if (c !== 256) begin
            errors++;
            $display("FAIL bitrev_latency: got %0d cycles required 256", c);
        end
    endtask

    task automatic test_stall;
        int c;
        start_stream(1'b0);
        check_stream(1'b0, 1'b0, 10, -1, 1'b0, 1'b0, c);
        checks++;
        if (c !== 259) begin
            errors++;
            $display("FAIL stall_latency: got %0d cycles required 259", c);
        end
    endtask

    task automatic test_start_ignored;
        int c;
        start_stream(1'b0);
        check_stream(1'b0, 1'b0, -1, 50, 1'b0, 1'b0, c);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || coef_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_after: got d/b/v=%b%b%b required 000",
                     done, busy, coef_valid);
        end
        bitrev = 1'b0;
    endtask

    task automatic test_reset_mid;
        int c;
        coef_ready = 1'b1;
        start_stream(1'b0);
        repeat (100) tick();
        checks++;
        if (coef_out !== 12'd100) begin
            errors++;
            $display("FAIL reset_mid_pre: got %0d required 100", coef_out);
        end
        #3;
        rst = 1'b1;
        #1;
        test_reset();
        #2;
        rst = 1'b0;
        tick();
        start_stream(1'b0);
        check_stream(1'b0, 1'b0, -1, -1, 1'b0, 1'b0, c);
        checks++;
        if (c !== 256) begin
            errors++;
            $display("FAIL reset_restart_latency: got %0d cycles required 256", c);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        start_stream(1'b0);
        check_stream(1'b0, 1'b1, -1, -1, 1'b1, 1'b1, c);
        check_stream(1'b1, 1'b1, -1, -1, 1'b1, 1'b0, c);
        check_stream(1'b0, 1'b1, -1, -1, 1'b0, 1'b0, c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        #1;
        preload();
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_natural();
        test_bitrev();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
